pin_capt_mc: RTL and testbench
==============================

PIN_CAPT_MC -- requirements
Module: pin_capt_mc

Interface
REQ-001 Parameter CH, default 4: number of independent capture channels.
REQ-002 Parameter OVS, default 8: samples per channel per clock; power of 2, >=2; TW = log2(OVS).
REQ-003 Parameter WW, default 8: pulse-width field width in samples.
REQ-004 Parameter CW, default 16: coarse timestamp counter width.
REQ-005 Parameter MIN_WIDTH, default 2: minimum accepted pulse width in samples; range 1..2^WW-1.
REQ-006 clk300  input  1  sole clock, rising-edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  capture enable.
REQ-009 clr_drop  input  1  clears all drop flags.
REQ-010 inv  input  CH  per-channel input inversion; quasi-static.
REQ-011 pin_in  input  CH*OVS  oversampled word; channel c occupies bits [c*OVS +: OVS]; bit 0 is the earliest sample.
REQ-012 str  output  CH  one-cycle event strobe per channel.
REQ-013 ptime  output  CH*TW  rise sample index within its word.
REQ-014 tstamp  output  CH*CW  coarse counter value for the word containing the rise.
REQ-015 pwidth  output  CH*WW  pulse width in samples, saturating.
REQ-016 drop  output  CH  sticky flag: a qualified pulse was discarded.

Function
REQ-017 Coarse counter increments by 1 each cycle while en=1, wraps from 2^CW-1 to 0, holds while en=0.
REQ-018 Effective sample s[k] = pin_in bit XOR inv[c]; the previous sample of s[0] is the registered s[OVS-1] of the prior word (the "last" register).
REQ-019 Each channel runs its FSM per sample in index order: IDLE (low); HIGH (pulse open).
REQ-020 IDLE -> HIGH at the first k with s[k]=1 and previous sample 0; latch ptime=k and tstamp=counter; width=1.
REQ-021 In HIGH, each sample s[k]=1 increments width, saturating at 2^WW-1.
REQ-022 HIGH -> IDLE at the first s[k]=0; the pulse qualifies iff width >= MIN_WIDTH; a non-qualifying pulse is discarded silently.
REQ-023 A pulse may span any number of words; state, width, ptime and tstamp persist across clock edges.
REQ-024 At most one event per channel per word; the first qualifying pulse to close in a word is reported; any further qualifying pulse closing in the same word sets drop[c].
REQ-025 Latency: str[c] asserts on the clock edge after the word containing the closing 0 is sampled (1 cycle), with ptime/tstamp/pwidth valid in the same cycle.
REQ-026 ptime/tstamp/pwidth hold their last reported values while str=0.
REQ-027 drop[c] stays set until clr_drop=1 or rst; if clr_drop and a new drop coincide, drop stays set.
REQ-028 en=0: channel FSMs forced to IDLE, last registers loaded with 1, no str, open pulses discarded without setting drop.
REQ-029 After en or rst deasserts, a channel already high does not produce a rise until it has gone low first.

Reset
REQ-030 rst=1 at a clock edge: str=0, ptime=0, tstamp=0, pwidth=0, drop=0, counter=0, all FSMs IDLE, all last registers=1.
REQ-031 rst takes priority over en and clr_drop; a pulse open at reset is discarded and never reported.

Verification (CH=4, OVS=8, WW=8, CW=16, MIN_WIDTH=2, inv=0)
REQ-032 Ch0 words 0x00, 0x38, 0x00 with counter=5 on the 0x38 word -> str[0] one cycle after that word; ptime=3, tstamp=5, pwidth=3.
REQ-033 Ch1 words 0xC0, 0xFF, 0x03, 0x00 with counter=10 on the first word -> single str[1] one cycle after the 0x03 word; ptime=6, tstamp=10, pwidth=12.
REQ-034 Ch2 word 0x10 (1-sample glitch) then 0x00 -> no str, drop=0; same with MIN_WIDTH=1 -> str with ptime=4, pwidth=1.
REQ-035 Ch3 word 0x66 (pulses at 1..2 and 5..6) -> str with ptime=1, pwidth=2, drop[3]=1; clr_drop pulse -> drop[3]=0.
REQ-036 Ch0 held high through 300 words then low -> pwidth=255; inv[0]=1 with all-zero input -> no str until a 1 appears, then events on 1->0 transitions of the raw input.
REQ-037 rst asserted mid-pulse on ch1 with the input still high -> no str; ch1 reports nothing until the input returns low and rises again.

Source files
------------

// File: rtl/pin_capt_mc.sv
// Multi-channel oversampled pulse capture.
// Each clock brings OVS samples per channel. Every channel walks its samples in
// index order through a two-state FSM (IDLE / HIGH) that finds rising edges,
// measures pulse width and reports the first qualifying pulse to close in the
// word. The report carries the rise sample index and a coarse timestamp.
// Ports:
//   clk300, rst       clock and synchronous active-high reset
//   en                capture enable; also gates the coarse counter
//   clr_drop          clears all sticky drop flags
//   inv[CH]           per-channel input inversion
//   pin_in[CH*OVS]    oversampled inputs, channel c at [c*OVS +: OVS], bit 0 earliest
//   str[CH]           one-cycle event strobe
//   ptime[CH*TW]      rise sample index within its word
//   tstamp[CH*CW]     coarse counter value of the word containing the rise
//   pwidth[CH*WW]     pulse width in samples, saturating
//   drop[CH]          sticky: a qualifying pulse was discarded
module pin_capt_mc #(
   parameter int unsigned CH        = 4,
   parameter int unsigned OVS       = 8,
   parameter int unsigned WW        = 8,
   parameter int unsigned CW        = 16,
   parameter int unsigned MIN_WIDTH = 2,
   localparam int unsigned TW       = $clog2(OVS)
) (
   input  logic              clk300,
   input  logic              rst,
   input  logic              en,
   input  logic              clr_drop,
   input  logic [CH-1:0]     inv,
   input  logic [CH*OVS-1:0] pin_in,
   output logic [CH-1:0]     str,
   output logic [CH*TW-1:0]  ptime,
   output logic [CH*CW-1:0]  tstamp,
   output logic [CH*WW-1:0]  pwidth,
   output logic [CH-1:0]     drop
);

   typedef enum logic {S_IDLE = 1'b0, S_HIGH = 1'b1} state_t;

   localparam logic [WW-1:0] W_MAX = {WW{1'b1}};
   localparam logic [WW-1:0] W_MIN = WW'(MIN_WIDTH);

   logic [CW-1:0] cnt_q;

   // Per-channel open-pulse context, carried across words
   state_t        st_q  [CH];
   logic [WW-1:0] wid_q [CH];
   logic [TW-1:0] opt_q [CH];
   logic [CW-1:0] ots_q [CH];
   logic [CH-1:0] last_q;

   state_t        st_d  [CH];
   logic [WW-1:0] wid_d [CH];
   logic [TW-1:0] opt_d [CH];
   logic [CW-1:0] ots_d [CH];
   logic [CH-1:0] last_d;

   logic [CH-1:0]    str_d;
   logic [CH*TW-1:0] ptime_d;
   logic [CH*CW-1:0] tstamp_d;
   logic [CH*WW-1:0] pwidth_d;
   logic [CH-1:0]    drop_set;

   // Sample-serial FSM walk over one word for every channel
   always_comb begin
      state_t        st;
      logic [WW-1:0] w;
      logic [TW-1:0] opt;
      logic [CW-1:0] ots;
      logic          prev;
      logic          s;
      logic          rep;

      str_d    = '0;
      ptime_d  = ptime;
      tstamp_d = tstamp;
      pwidth_d = pwidth;
      drop_set = '0;
      st       = S_IDLE;
      w        = '0;
      opt      = '0;
      ots      = '0;
      prev     = 1'b1;
      s        = 1'b0;
      rep      = 1'b0;

      for (int c = 0; c < CH; c++) begin
         st   = st_q[c];
         w    = wid_q[c];
         opt  = opt_q[c];
         ots  = ots_q[c];
         prev = last_q[c];
         rep  = 1'b0;
         for (int k = 0; k < OVS; k++) begin
            s = pin_in[c*OVS + k] ^ inv[c];
            if (st == S_IDLE) begin
               // Only a genuine 0->1 opens a pulse; a level already high is ignored
               if (s && !prev) begin
                  st  = S_HIGH;
                  opt = TW'(k);
                  ots = cnt_q;
                  w   = WW'(1);
               end
            end else if (s) begin
               if (w != W_MAX) w = w + WW'(1);
            end else begin
               st = S_IDLE;
               if (w >= W_MIN) begin
                  if (!rep) begin
                     rep                   = 1'b1;
                     str_d[c]              = 1'b1;
                     ptime_d[c*TW +: TW]   = opt;
                     tstamp_d[c*CW +: CW]  = ots;
                     pwidth_d[c*WW +: WW]  = w;
                  end else begin
                     drop_set[c] = 1'b1;
                  end
               end
            end
            prev = s;
         end
         st_d[c]   = st;
         wid_d[c]  = w;
         opt_d[c]  = opt;
         ots_d[c]  = ots;
         last_d[c] = prev;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk300) begin
      if (rst) begin
         cnt_q  <= '0;
         last_q <= '1;
         str    <= '0;
         ptime  <= '0;
         tstamp <= '0;
         pwidth <= '0;
         drop   <= '0;
         for (int c = 0; c < CH; c++) begin
            st_q[c]  <= S_IDLE;
            wid_q[c] <= '0;
            opt_q[c] <= '0;
            ots_q[c] <= '0;
         end
      end else begin
         // A new drop wins over a coincident clear
         drop <= (drop & ~{CH{clr_drop}}) | (en ? drop_set : '0);
         if (en) begin
            cnt_q  <= cnt_q + CW'(1);
            last_q <= last_d;
            str    <= str_d;
            ptime  <= ptime_d;
            tstamp <= tstamp_d;
            pwidth <= pwidth_d;
            for (int c = 0; c < CH; c++) begin
               st_q[c]  <= st_d[c];
               wid_q[c] <= wid_d[c];
               opt_q[c] <= opt_d[c];
               ots_q[c] <= ots_d[c];
            end
         end else begin
            // Disabled: abandon open pulses; last=1 blocks a false rise on re-enable
            last_q <= '1;
            str    <= '0;
            for (int c = 0; c < CH; c++) st_q[c] <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_pin_capt_mc.sv
// Directed bench for pin_capt_mc (CH=4, OVS=8, WW=8, CW=16). A second instance
// with MIN_WIDTH=1 shares the inputs to cover the single-sample pulse case.
module tb_pin_capt_mc;

   logic        clk300 = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        clr_drop = 1'b0;
   logic [3:0]  inv = 4'b0000;
   logic [31:0] pin_in = '0;

   logic [3:0]  str,    str1;
   logic [11:0] ptime,  ptime1;
   logic [63:0] tstamp, tstamp1;
   logic [31:0] pwidth, pwidth1;
   logic [3:0]  drop,   drop1;

   int total = 0;
   int bad = 0;

   always #5 clk300 = ~clk300;

   pin_capt_mc #(.CH(4), .OVS(8), .WW(8), .CW(16), .MIN_WIDTH(2)) dut (
      .clk300(clk300), .rst(rst), .en(en), .clr_drop(clr_drop), .inv(inv),
      .pin_in(pin_in), .str(str), .ptime(ptime), .tstamp(tstamp),
      .pwidth(pwidth), .drop(drop));

   pin_capt_mc #(.CH(4), .OVS(8), .WW(8), .CW(16), .MIN_WIDTH(1)) dut1 (
      .clk300(clk300), .rst(rst), .en(en), .clr_drop(clr_drop), .inv(inv),
      .pin_in(pin_in), .str(str1), .ptime(ptime1), .tstamp(tstamp1),
      .pwidth(pwidth1), .drop(drop1));

   // Outputs sampled 1 time unit after the active edge
   task automatic tick;
      @(posedge clk300);
      #1;
   endtask

   task automatic drive(input int ch, input logic [7:0] v);
      pin_in = '0;
      pin_in[ch*8 +: 8] = v;
   endtask

   // Leaves the coarse counter at 0 for the next word
   task automatic reset_dut;
      rst = 1'b1; en = 1'b1; clr_drop = 1'b0; pin_in = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      reset_dut();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL reset_str got=%h exp=0", str); end
      total++; if (ptime !== 12'b0) begin bad++; $display("FAIL reset_ptime got=%h exp=0", ptime); end
      total++; if (tstamp !== 64'b0) begin bad++; $display("FAIL reset_tstamp got=%h exp=0", tstamp); end
      total++; if (pwidth !== 32'b0) begin bad++; $display("FAIL reset_pwidth got=%h exp=0", pwidth); end
      total++; if (drop !== 4'b0) begin bad++; $display("FAIL reset_drop got=%h exp=0", drop); end
   endtask

   task automatic test_basic;
      reset_dut();
      repeat (5) begin drive(0, 8'h00); tick(); end
      drive(0, 8'h38); tick();
      total++; if (str !== 4'b0001) begin bad++; $display("FAIL basic_str got=%h exp=1", str); end
      total++; if (ptime[0 +: 3] !== 3'd3) begin bad++; $display("FAIL basic_ptime got=%0d exp=3", ptime[0 +: 3]); end
      total++; if (tstamp[0 +: 16] !== 16'd5) begin bad++; $display("FAIL basic_tstamp got=%0d exp=5", tstamp[0 +: 16]); end
      total++; if (pwidth[0 +: 8] !== 8'd3) begin bad++; $display("FAIL basic_pwidth got=%0d exp=3", pwidth[0 +: 8]); end
      drive(0, 8'h00); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL basic_str_off got=%h exp=0", str); end
      total++; if (ptime[0 +: 3] !== 3'd3) begin bad++; $display("FAIL basic_hold got=%0d exp=3", ptime[0 +: 3]); end
   endtask

   task automatic test_multiword;
      reset_dut();
      repeat (10) begin drive(1, 8'h00); tick(); end
      drive(1, 8'hC0); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL mw_str_w0 got=%h exp=0", str); end
      drive(1, 8'hFF); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL mw_str_w1 got=%h exp=0", str); end
      drive(1, 8'h03); tick();
      total++; if (str !== 4'b0010) begin bad++; $display("FAIL mw_str got=%h exp=2", str); end
      total++; if (ptime[3 +: 3] !== 3'd6) begin bad++; $display("FAIL mw_ptime got=%0d exp=6", ptime[3 +: 3]); end
      total++; if (tstamp[16 +: 16] !== 16'd10) begin bad++; $display("FAIL mw_tstamp got=%0d exp=10", tstamp[16 +: 16]); end
      total++; if (pwidth[8 +: 8] !== 8'd12) begin bad++; $display("FAIL mw_pwidth got=%0d exp=12", pwidth[8 +: 8]); end
      drive(1, 8'h00); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL mw_single got=%h exp=0", str); end
   endtask

   task automatic test_glitch;
      reset_dut();
      drive(2, 8'h00); tick();
      drive(2, 8'h10); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL glitch_str got=%h exp=0", str); end
      total++; if (str1 !== 4'b0100) begin bad++; $display("FAIL glitch_str_min1 got=%h exp=4", str1); end
      total++; if (ptime1[6 +: 3] !== 3'd4) begin bad++; $display("FAIL glitch_ptime_min1 got=%0d exp=4", ptime1[6 +: 3]); end
      total++; if (pwidth1[16 +: 8] !== 8'd1) begin bad++; $display("FAIL glitch_pwidth_min1 got=%0d exp=1", pwidth1[16 +: 8]); end
      total++; if (tstamp1[32 +: 16] !== 16'd1) begin bad++; $display("FAIL glitch_tstamp_min1 got=%0d exp=1", tstamp1[32 +: 16]); end
      drive(2, 8'h00); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL glitch_str_after got=%h exp=0", str); end
      total++; if (drop !== 4'b0) begin bad++; $display("FAIL glitch_drop got=%h exp=0", drop); end
   endtask

   task automatic test_drop;
      reset_dut();
      drive(3, 8'h00); tick();
      drive(3, 8'h66); tick();
      total++; if (str !== 4'b1000) begin bad++; $display("FAIL drop_str got=%h exp=8", str); end
      total++; if (ptime[9 +: 3] !== 3'd1) begin bad++; $display("FAIL drop_ptime got=%0d exp=1", ptime[9 +: 3]); end
      total++; if (pwidth[24 +: 8] !== 8'd2) begin bad++; $display("FAIL drop_pwidth got=%0d exp=2", pwidth[24 +: 8]); end
      total++; if (drop !== 4'b1000) begin bad++; $display("FAIL drop_set got=%h exp=8", drop); end
      total++; if (drop1 !== 4'b1000) begin bad++; $display("FAIL drop_set_min1 got=%h exp=8", drop1); end
      drive(3, 8'h00); tick();
      total++; if (drop !== 4'b1000) begin bad++; $display("FAIL drop_sticky got=%h exp=8", drop); end
      clr_drop = 1'b1; drive(3, 8'h66); tick();
      total++; if (drop !== 4'b1000) begin bad++; $display("FAIL drop_clr_coincide got=%h exp=8", drop); end
      total++; if (str !== 4'b1000) begin bad++; $display("FAIL drop_str2 got=%h exp=8", str); end
      drive(3, 8'h00); tick();
      clr_drop = 1'b0;
      total++; if (drop !== 4'b0) begin bad++; $display("FAIL drop_clear got=%h exp=0", drop); end
   endtask

   task automatic test_saturate;
      int nstr;
      nstr = 0;
      reset_dut();
      drive(0, 8'h00); tick();
      repeat (300) begin
         drive(0, 8'hFF); tick();
         if (str !== 4'b0) nstr++;
      end
      total++; if (nstr !== 0) begin bad++; $display("FAIL sat_early_str got=%0d exp=0", nstr); end
      drive(0, 8'h00); tick();
      total++; if (str !== 4'b0001) begin bad++; $display("FAIL sat_str got=%h exp=1", str); end
      total++; if (ptime[0 +: 3] !== 3'd0) begin bad++; $display("FAIL sat_ptime got=%0d exp=0", ptime[0 +: 3]); end
      total++; if (pwidth[0 +: 8] !== 8'd255) begin bad++; $display("FAIL sat_pwidth got=%0d exp=255", pwidth[0 +: 8]); end
   endtask

   task automatic test_invert;
      int nstr;
      nstr = 0;
      inv = 4'b0001;
      reset_dut();
      repeat (3) begin
         drive(0, 8'h00); tick();
         if (str !== 4'b0) nstr++;
      end
      total++; if (nstr !== 0) begin bad++; $display("FAIL inv_idle_str got=%0d exp=0", nstr); end
      drive(0, 8'h0F); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL inv_open_str got=%h exp=0", str); end
      drive(0, 8'h01); tick();
      total++; if (str !== 4'b0001) begin bad++; $display("FAIL inv_str got=%h exp=1", str); end
      total++; if (ptime[0 +: 3] !== 3'd4) begin bad++; $display("FAIL inv_ptime got=%0d exp=4", ptime[0 +: 3]); end
      total++; if (pwidth[0 +: 8] !== 8'd4) begin bad++; $display("FAIL inv_pwidth got=%0d exp=4", pwidth[0 +: 8]); end
      inv = 4'b0000;
   endtask

   task automatic test_enable;
      reset_dut();
      drive(1, 8'h00); tick();
      drive(1, 8'hE0); tick();
      en = 1'b0; drive(1, 8'hC0); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL en_off_str got=%h exp=0", str); end
      en = 1'b1; drive(1, 8'h00); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL en_discard_str got=%h exp=0", str); end
      total++; if (drop !== 4'b0) begin bad++; $display("FAIL en_discard_drop got=%h exp=0", drop); end
      drive(1, 8'h0C); tick();
      total++; if (str !== 4'b0010) begin bad++; $display("FAIL en_str got=%h exp=2", str); end
      total++; if (ptime[3 +: 3] !== 3'd2) begin bad++; $display("FAIL en_ptime got=%0d exp=2", ptime[3 +: 3]); end
      total++; if (tstamp[16 +: 16] !== 16'd3) begin bad++; $display("FAIL en_tstamp_hold got=%0d exp=3", tstamp[16 +: 16]); end
   endtask

   // Continues from test_enable so outputs are non-zero going into reset
   task automatic test_reset_mid;
      int nstr;
      nstr = 0;
      drive(1, 8'h00); tick();
      drive(1, 8'hF0); tick();
      rst = 1'b1; drive(1, 8'hFF); tick();
      rst = 1'b0;
      total++; if (str !== 4'b0) begin bad++; $display("FAIL rmid_str got=%h exp=0", str); end
      total++; if (ptime !== 12'b0) begin bad++; $display("FAIL rmid_ptime got=%h exp=0", ptime); end
      total++; if (tstamp !== 64'b0) begin bad++; $display("FAIL rmid_tstamp got=%h exp=0", tstamp); end
      repeat (2) begin
         drive(1, 8'hFF); tick();
         if (str !== 4'b0) nstr++;
      end
      drive(1, 8'h0F); tick();
      if (str !== 4'b0) nstr++;
      total++; if (nstr !== 0) begin bad++; $display("FAIL rmid_no_rise got=%0d exp=0", nstr); end
      drive(1, 8'h30); tick();
      total++; if (str !== 4'b0010) begin bad++; $display("FAIL rmid_str2 got=%h exp=2", str); end
      total++; if (ptime[3 +: 3] !== 3'd4) begin bad++; $display("FAIL rmid_ptime2 got=%0d exp=4", ptime[3 +: 3]); end
      total++; if (pwidth[8 +: 8] !== 8'd2) begin bad++; $display("FAIL rmid_pwidth2 got=%0d exp=2", pwidth[8 +: 8]); end
      total++; if (tstamp[16 +: 16] !== 16'd3) begin bad++; $display("FAIL rmid_tstamp2 got=%0d exp=3", tstamp[16 +: 16]); end
   endtask

   task automatic test_back_to_back;
      reset_dut();
      drive(2, 8'h00); tick();
      drive(2, 8'h06); tick();
      total++; if (str !== 4'b0100) begin bad++; $display("FAIL b2b_str0 got=%h exp=4", str); end
      total++; if (ptime[6 +: 3] !== 3'd1) begin bad++; $display("FAIL b2b_ptime0 got=%0d exp=1", ptime[6 +: 3]); end
      total++; if (tstamp[32 +: 16] !== 16'd1) begin bad++; $display("FAIL b2b_tstamp0 got=%0d exp=1", tstamp[32 +: 16]); end
      drive(2, 8'h60); tick();
      total++; if (str !== 4'b0100) begin bad++; $display("FAIL b2b_str1 got=%h exp=4", str); end
      total++; if (ptime[6 +: 3] !== 3'd5) begin bad++; $display("FAIL b2b_ptime1 got=%0d exp=5", ptime[6 +: 3]); end
      total++; if (tstamp[32 +: 16] !== 16'd2) begin bad++; $display("FAIL b2b_tstamp1 got=%0d exp=2", tstamp[32 +: 16]); end
      drive(2, 8'h80); tick();
      total++; if (str !== 4'b0) begin bad++; $display("FAIL b2b_span_open got=%h exp=0", str); end
      drive(2, 8'h01); tick();
      total++; if (str !== 4'b0100) begin bad++; $display("FAIL b2b_span_str got=%h exp=4", str); end
      total++; if (ptime[6 +: 3] !== 3'd7) begin bad++; $display("FAIL b2b_span_ptime got=%0d exp=7", ptime[6 +: 3]); end
      total++; if (tstamp[32 +: 16] !== 16'd3) begin bad++; $display("FAIL b2b_span_tstamp got=%0d exp=3", tstamp[32 +: 16]); end
      total++; if (pwidth[16 +: 8] !== 8'd2) begin bad++; $display("FAIL b2b_span_pwidth got=%0d exp=2", pwidth[16 +: 8]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_multiword();
      test_glitch();
      test_drop();
      test_saturate();
      test_invert();
      test_enable();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
